// File: rtl/video_timing_tracker.sv
// Video timing tracker: one-cycle pass-through of sync/data with pixel coordinates,
// frame/line markers and a lock monitor that counts timing violations.
module video_timing_tracker #(
  parameter int unsigned H_WIDTH     = 1920,
  parameter int unsigned V_HEIGHT    = 1080,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        vs_i,
  input  logic        hs_i,
  input  logic        de_i,
  input  logic [23:0] data_i,
  output logic        vs_o,
  output logic        hs_o,
  output logic        de_o,
  output logic [23:0] data_o,
  output logic [11:0] x_o,
  output logic [10:0] y_o,
  output logic        sof_o,
  output logic        eol_o,
  output logic        locked_o,
  output logic [7:0]  err_cnt_o
);

  localparam int unsigned DATA_W = 24;
  localparam int unsigned X_W    = 12;
  localparam int unsigned Y_W    = 11;
  localparam int unsigned RUN_W  = 13;
  localparam int unsigned LINE_W = 12;
  localparam int unsigned GOOD_W = 4;
  localparam int unsigned ERR_W  = 8;

  typedef enum logic [1:0] {
    S_UNLOCKED = 2'd0,
    S_CHECK    = 2'd1,
    S_LOCKED   = 2'd2
  } state_t;

  logic              r_vs, r_hs, r_de, r_sof;
  logic [DATA_W-1:0] r_data;
  logic [X_W-1:0]    r_x, w_x_nxt;
  logic [Y_W-1:0]    r_y, w_y_nxt;
  logic [RUN_W-1:0]  r_run, w_run_nxt;
  logic [LINE_W-1:0] r_lines, w_lines_nxt, w_lines_incl;
  logic              r_discard, w_discard_nxt;
  logic              r_frame_bad;
  logic [GOOD_W-1:0] r_good, w_good_sum;
  logic [ERR_W-1:0]  r_err;
  state_t            r_state, w_state_nxt;

  logic w_vs_rise, w_de_rise, w_de_fall;
  logic w_line_end, w_line_bad, w_frame_bad;
  logic w_good_clr, w_good_inc, w_err_inc;

  // Edges are taken against the registered samples, which reset to 0.
  assign w_vs_rise = vs_i & ~r_vs;
  assign w_de_rise = de_i & ~r_de;
  assign w_de_fall = ~de_i & r_de;

  // A vs rise in the middle of a run closes that line early; the remnant is discarded.
  assign w_line_end   = r_de & (~de_i | w_vs_rise) & ~r_discard;
  assign w_line_bad   = w_line_end & (r_run != RUN_W'(H_WIDTH));
  assign w_lines_incl = (w_line_end && (r_lines != '1)) ? r_lines + LINE_W'(1) : r_lines;
  assign w_frame_bad  = r_frame_bad | w_line_bad | (w_lines_incl != LINE_W'(V_HEIGHT));

  always_comb begin
    w_x_nxt       = r_x;
    w_y_nxt       = r_y;
    w_run_nxt     = r_run;
    w_lines_nxt   = r_lines;
    w_discard_nxt = r_discard;
    if (de_i) begin
      if (w_de_rise) begin
        w_x_nxt   = '0;
        w_run_nxt = RUN_W'(1);
      end else begin
        w_x_nxt   = (r_x == '1) ? r_x : r_x + X_W'(1);
        w_run_nxt = (r_run == '1) ? r_run : r_run + RUN_W'(1);
      end
    end
    if (w_line_end) begin
      w_y_nxt     = (r_y == '1) ? r_y : r_y + Y_W'(1);
      w_lines_nxt = w_lines_incl;
    end
    if (w_de_fall) begin
      w_discard_nxt = 1'b0;
    end
    if (w_vs_rise) begin
      w_y_nxt     = '0;
      w_lines_nxt = '0;
      if (r_de && de_i) begin
        w_discard_nxt = 1'b1;
      end
    end
  end

  // Pass-through pipeline and position tracking.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_vs        <= 1'b0;
      r_hs        <= 1'b0;
      r_de        <= 1'b0;
      r_data      <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_sof       <= 1'b0;
      r_run       <= '0;
      r_lines     <= '0;
      r_discard   <= 1'b0;
      r_frame_bad <= 1'b0;
    end else begin
      r_vs        <= vs_i;
      r_hs        <= hs_i;
      r_de        <= de_i;
      r_data      <= data_i;
      r_x         <= w_x_nxt;
      r_y         <= w_y_nxt;
      r_sof       <= de_i & (w_x_nxt == '0) & (w_y_nxt == '0);
      r_run       <= w_run_nxt;
      r_lines     <= w_lines_nxt;
      r_discard   <= w_discard_nxt;
      if (w_vs_rise) begin
        r_frame_bad <= 1'b0;
      end else if (w_line_bad) begin
        r_frame_bad <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_UNLOCKED;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  assign w_good_sum = r_good + GOOD_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_UNLOCKED: begin
        if (w_vs_rise) begin
          w_state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        if (w_vs_rise) begin
          if (w_frame_bad) begin
            w_state_nxt = S_UNLOCKED;
          end else if (w_good_sum >= GOOD_W'(LOCK_FRAMES)) begin
            w_state_nxt = S_LOCKED;
          end
        end
      end
      S_LOCKED: begin
        if (w_line_bad || (w_vs_rise && w_frame_bad)) begin
          w_state_nxt = S_UNLOCKED;
        end
      end
      default: w_state_nxt = S_UNLOCKED;
    endcase
  end

  // One error per unlock event, so a bad line and its bad frame count once.
  always_comb begin
    w_good_clr = 1'b0;
    w_good_inc = 1'b0;
    w_err_inc  = 1'b0;
    case (r_state)
      S_UNLOCKED: w_good_clr = w_vs_rise;
      S_CHECK:    w_good_inc = w_vs_rise & ~w_frame_bad;
      S_LOCKED:   w_err_inc  = w_line_bad | (w_vs_rise & w_frame_bad);
      default:    w_good_clr = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_good <= '0;
      r_err  <= '0;
    end else begin
      if (w_good_clr) begin
        r_good <= '0;
      end else if (w_good_inc) begin
        r_good <= w_good_sum;
      end
      if (w_err_inc && (r_err != '1)) begin
        r_err <= r_err + ERR_W'(1);
      end
    end
  end

  assign vs_o      = r_vs;
  assign hs_o      = r_hs;
  assign de_o      = r_de;
  assign data_o    = r_data;
  assign x_o       = r_x;
  assign y_o       = r_y;
  assign sof_o     = r_sof;
  assign err_cnt_o = r_err;
  assign locked_o  = (r_state == S_LOCKED);
  // End of line needs one sample of lookahead, so it decodes the live de_i.
  assign eol_o     = r_de & ~de_i & ~rst_i;

endmodule

// File: tb/tb_video_timing_tracker.sv
// Directed bench for video_timing_tracker using a small 6x3 raster so whole
// frames, relock sequences and error-counter saturation fit in a short run.
module tb_video_timing_tracker;

  localparam int unsigned H  = 6;
  localparam int unsigned V  = 3;
  localparam int unsigned LF = 2;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        vs_i, hs_i, de_i;
  logic [23:0] data_i;
  logic        vs_o, hs_o, de_o;
  logic [23:0] data_o;
  logic [11:0] x_o;
  logic [10:0] y_o;
  logic        sof_o, eol_o, locked_o;
  logic [7:0]  err_cnt_o;

  int errors = 0;
  int checks = 0;

  video_timing_tracker #(.H_WIDTH(H), .V_HEIGHT(V), .LOCK_FRAMES(LF)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .vs_i(vs_i), .hs_i(hs_i), .de_i(de_i),
    .data_i(data_i), .vs_o(vs_o), .hs_o(hs_o), .de_o(de_o), .data_o(data_o),
    .x_o(x_o), .y_o(y_o), .sof_o(sof_o), .eol_o(eol_o), .locked_o(locked_o),
    .err_cnt_o(err_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic cyc(input logic v, input logic d, input logic [23:0] dat);
    vs_i = v; de_i = d; hs_i = 1'b0; data_i = dat;
    @(posedge clk_i); #1;
  endtask

  task automatic vsync(input int exp_lock);
    cyc(1'b1, 1'b0, 24'h0);
    if (exp_lock >= 0) begin
      checks++;
      if (locked_o !== 1'(exp_lock)) begin
        errors++; $display("FAIL locked_after_vs: got %0b want %0d", locked_o, exp_lock);
      end
    end
    cyc(1'b1, 1'b0, 24'h0);
    cyc(1'b0, 1'b0, 24'h0);
    cyc(1'b0, 1'b0, 24'h0);
  endtask

  task automatic send_line(input int l, input int len, input bit chk, input int exp_lock,
                           output int nsof);
    logic [23:0] dat;
    nsof = 0;
    for (int p = 0; p < len; p++) begin
      dat = {8'(l), 8'(p), 8'h5A};
      cyc(1'b0, 1'b1, dat);
      if (sof_o) nsof++;
      if (chk) begin
        checks++;
        if (x_o !== 12'(p)) begin
          errors++; $display("FAIL x_o l%0d p%0d: got %0d want %0d", l, p, x_o, p);
        end
        checks++;
        if (y_o !== 11'(l)) begin
          errors++; $display("FAIL y_o l%0d p%0d: got %0d want %0d", l, p, y_o, l);
        end
        checks++;
        if (data_o !== dat || de_o !== 1'b1) begin
          errors++; $display("FAIL data_o l%0d p%0d: got %h/%0b want %h/1", l, p, data_o, de_o, dat);
        end
        checks++;
        if (sof_o !== ((p == 0 && l == 0) ? 1'b1 : 1'b0)) begin
          errors++; $display("FAIL sof_o l%0d p%0d: got %0b", l, p, sof_o);
        end
        if (p == 0) begin
          checks++;
          if (eol_o !== 1'b0) begin
            errors++; $display("FAIL eol_early l%0d: got %0b want 0", l, eol_o);
          end
        end
      end
    end
    vs_i = 1'b0; de_i = 1'b0; hs_i = 1'b1; #1;
    if (chk) begin
      checks++;
      if (eol_o !== 1'b1) begin
        errors++; $display("FAIL eol_o l%0d: got %0b want 1", l, eol_o);
      end
    end
    @(posedge clk_i); #1;
    if (chk) begin
      checks++;
      if (hs_o !== 1'b1 || de_o !== 1'b0) begin
        errors++; $display("FAIL hs/de blank l%0d: got %0b/%0b want 1/0", l, hs_o, de_o);
      end
    end
    if (exp_lock >= 0) begin
      checks++;
      if (locked_o !== 1'(exp_lock)) begin
        errors++; $display("FAIL locked_after_line l%0d: got %0b want %0d", l, locked_o, exp_lock);
      end
    end
    cyc(1'b0, 1'b0, 24'h0);
  endtask

  task automatic send_body(input int nlines, input int bad_line, input int bad_len,
                           input bit chk, input int bad_lock);
    int n;
    int total;
    total = 0;
    for (int l = 0; l < nlines; l++) begin
      send_line(l, (l == bad_line) ? bad_len : int'(H), chk, (l == bad_line) ? bad_lock : -1, n);
      total += n;
    end
    if (chk) begin
      checks++;
      if (total != 1) begin
        errors++; $display("FAIL sof_count: got %0d want 1", total);
      end
    end
  endtask

  task automatic check_err(input int exp, input string tag);
    checks++;
    if (err_cnt_o !== 8'(exp)) begin
      errors++; $display("FAIL err_cnt %s: got %0d want %0d", tag, err_cnt_o, exp);
    end
  endtask

  task automatic check_reset_zero(input string tag);
    checks++;
    if ({vs_o, hs_o, de_o, sof_o, eol_o, locked_o} !== 6'b0 || data_o !== 24'h0 ||
        x_o !== 12'h0 || y_o !== 11'h0 || err_cnt_o !== 8'h0) begin
      errors++;
      $display("FAIL reset_%s: vs%0b hs%0b de%0b sof%0b eol%0b lk%0b d=%h x=%0d y=%0d err=%0d want all 0",
               tag, vs_o, hs_o, de_o, sof_o, eol_o, locked_o, data_o, x_o, y_o, err_cnt_o);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    cyc(1'b1, 1'b1, 24'hFFFFFF);
    hs_i = 1'b1; #1;
    check_reset_zero("active_inputs");
    cyc(1'b1, 1'b0, 24'hFFFFFF);
    check_reset_zero("de_low");
    rst_i = 1'b0;
    cyc(1'b0, 1'b0, 24'h0);
  endtask

  task automatic test_nominal();
    vsync(0);
    send_body(V, -1, 0, 1'b1, -1);
    vsync(0);
    send_body(V, -1, 0, 1'b1, -1);
    vsync(1);
    send_body(V, -1, 0, 1'b1, -1);
    vsync(1);
    check_err(0, "nominal");
  endtask

  task automatic test_short_line();
    send_body(V, 1, H - 1, 1'b1, 0);
    check_err(1, "short_line");
    vsync(0);
    send_body(V, -1, 0, 1'b0, -1);
    vsync(0);
    send_body(V, -1, 0, 1'b0, -1);
    vsync(1);
    check_err(1, "short_line_relock");
  endtask

  task automatic test_short_frame();
    send_body(V - 1, -1, 0, 1'b1, -1);
    vsync(0);
    check_err(2, "short_frame");
    send_body(V, -1, 0, 1'b0, -1);
    vsync(0);
    send_body(V, -1, 0, 1'b0, -1);
    vsync(0);
    send_body(V, -1, 0, 1'b0, -1);
    vsync(1);
  endtask

  task automatic test_vs_during_de();
    int n;
    send_line(0, H, 1'b1, -1, n);
    send_line(1, H, 1'b1, -1, n);
    for (int p = 0; p < 3; p++) cyc(1'b0, 1'b1, 24'h0);
    cyc(1'b1, 1'b1, 24'h123456);
    checks++;
    if (locked_o !== 1'b0) begin
      errors++; $display("FAIL vs_de_unlock: got %0b want 0", locked_o);
    end
    check_err(3, "vs_de");
    checks++;
    if (x_o !== 12'd3 || y_o !== 11'd0 || sof_o !== 1'b0 || data_o !== 24'h123456) begin
      errors++; $display("FAIL vs_de_pos: x=%0d y=%0d sof=%0b d=%h want 3/0/0/123456", x_o, y_o, sof_o, data_o);
    end
    cyc(1'b1, 1'b1, 24'h0);
    cyc(1'b1, 1'b0, 24'h0);
    cyc(1'b0, 1'b0, 24'h0);
    cyc(1'b0, 1'b0, 24'h0);
    send_body(V, -1, 0, 1'b1, -1);
    vsync(0);
    check_err(3, "vs_de_once");
    send_body(V, -1, 0, 1'b0, -1);
    vsync(0);
    send_body(V, -1, 0, 1'b0, -1);
    vsync(1);
    check_err(3, "vs_de_relock");
  endtask

  task automatic test_reset_midframe();
    int n;
    send_line(0, H, 1'b0, -1, n);
    for (int p = 0; p < 3; p++) cyc(1'b0, 1'b1, 24'hABCDEF);
    rst_i = 1'b1;
    cyc(1'b0, 1'b1, 24'hABCDEF);
    #1;
    check_reset_zero("midline");
    cyc(1'b0, 1'b1, 24'hABCDEF);
    rst_i = 1'b0;
    cyc(1'b0, 1'b1, 24'h0);
    cyc(1'b0, 1'b1, 24'h0);
    cyc(1'b0, 1'b0, 24'h0);
    cyc(1'b0, 1'b0, 24'h0);
    send_line(2, H, 1'b0, -1, n);
    vsync(0);
    send_body(V, -1, 0, 1'b0, -1);
    vsync(0);
    send_body(V, -1, 0, 1'b0, -1);
    vsync(1);
    check_err(0, "after_reset");
  endtask

  task automatic test_err_saturation();
    for (int i = 0; i < 300; i++) begin
      send_body(V - 1, -1, 0, 1'b0, -1);
      vsync(0);
      check_err((i + 1 > 255) ? 255 : i + 1, "sat");
      send_body(V, -1, 0, 1'b0, -1);
      vsync(0);
      send_body(V, -1, 0, 1'b0, -1);
      vsync(0);
      send_body(V, -1, 0, 1'b0, -1);
      vsync(1);
    end
    check_err(255, "sat_final");
  endtask

  initial begin
    rst_i = 1'b1; vs_i = 1'b0; hs_i = 1'b0; de_i = 1'b0; data_i = 24'h0;
    test_reset();
    test_nominal();
    test_short_line();
    test_short_frame();
    test_vs_during_de();
    test_reset_midframe();
    test_err_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/video_timing_tracker.md
VIDEO_TIMING_TRACKER -- requirements
Module: video_timing_tracker

Interface
REQ-001 SHALL have parameter H_WIDTH, default 1920, active pixels per line.
REQ-002 SHALL have parameter V_HEIGHT, default 1080, active lines per frame.
REQ-003 SHALL have parameter LOCK_FRAMES, default 2, consecutive good frames required to lock (range 1..15).
REQ-004 SHALL have port clk_i, input, 1, pixel clock; the only clock.
REQ-005 SHALL have port rst_i, input, 1, reset; synchronous, active-high.
REQ-006 SHALL have port vs_i, input, 1, vertical sync, active-high.
REQ-007 SHALL have port hs_i, input, 1, horizontal sync, active-high.
REQ-008 SHALL have port de_i, input, 1, data enable.
REQ-009 SHALL have port data_i, input, 24, RGB pixel.
REQ-010 SHALL have ports vs_o, hs_o, de_o (output, 1 each) and data_o (output, 24): delayed copies of the inputs.
REQ-011 SHALL have port x_o, output, 12, column of the pixel on data_o.
REQ-012 SHALL have port y_o, output, 11, row of the pixel on data_o.
REQ-013 SHALL have port sof_o, output, 1, pulse on pixel (0,0).
REQ-014 SHALL have port eol_o, output, 1, pulse on the last de pixel of each line.
REQ-015 SHALL have port locked_o, output, 1, input timing matches the parameters.
REQ-016 SHALL have port err_cnt_o, output, 8, count of timing violations, saturating.

Function
REQ-017 SHALL register vs/hs/de/data, giving exactly 1-cycle latency; x_o, y_o, sof_o and eol_o SHALL be aligned to de_o.
REQ-018 SHALL detect edges against the previous registered samples: vs rise, de rise, de fall.
REQ-019 x_o SHALL be 0 on the first de pixel of a line, increment by 1 per de pixel, and saturate at 4095.
REQ-020 y_o SHALL be 0 for the first active line after a vs rise, increment by 1 at each de fall, and saturate at 2047.
REQ-021 sof_o SHALL be 1 iff de_o=1, x_o=0 and y_o=0; eol_o SHALL be 1 on the de_o cycle immediately preceding a de fall.
REQ-022 A line is bad if its de run length differs from H_WIDTH, checked at de fall.
REQ-023 A frame is bad if it contained a bad line or if its line count differs from V_HEIGHT, checked at the next vs rise.
REQ-024 SHALL implement FSM states UNLOCKED, CHECK, LOCKED.
REQ-025 UNLOCKED->CHECK on a vs rise; good-frame counter cleared.
REQ-026 In CHECK, each good frame increments the counter; at LOCK_FRAMES go to LOCKED; a bad frame returns to UNLOCKED.
REQ-027 In LOCKED, a bad line (at de fall) or a bad frame SHALL go to UNLOCKED the next cycle and increment err_cnt_o by 1, saturating at 255.
REQ-028 In LOCKED, a bad line followed by a bad frame in the same frame SHALL count only once.
REQ-029 locked_o SHALL be 1 iff state is LOCKED.
REQ-030 A vs rise occurring while de=1 SHALL close the line (counts as a de fall for the length check) and then start the new frame.
REQ-031 Counters SHALL run in all states; the pass-through path SHALL never be gated.

Reset
REQ-032 While rst_i=1: vs_o, hs_o, de_o, data_o, x_o, y_o, sof_o, eol_o and err_cnt_o SHALL be 0, and the state SHALL be UNLOCKED.
REQ-033 Reset asserted mid-line SHALL discard the partial line and frame; the first vs rise after release starts CHECK.
REQ-034 The edge detectors SHALL treat pre-reset samples as 0.

Verification
V-1 Reset, then 3 nominal 1920x1080 frames -> locked_o=1 after the 2nd frame's closing vs rise; err_cnt_o=0; sof_o fires once per frame; x_o sequence 0..1919.
V-2 Locked, then one line with de length 1919 -> locked_o=0 one cycle after that de fall; err_cnt_o=1; relock after 2 further good frames.
V-3 Locked, then a frame of 1079 lines -> unlock at the next vs rise; err_cnt_o increments by 1.
V-4 Alternating good/bad frames 300 times -> err_cnt_o saturates at 255; no wrap.
V-5 vs rise during de at x=500 -> line flagged bad; y_o=0 on the next line; exactly one error counted.
V-6 rst_i pulsed mid-frame while locked -> all outputs 0 during reset; err_cnt_o=0; locked_o=1 again after 2 complete good frames.
